// File: rtl/video_timing_gen_pkg.sv
// video_timing_pkg: standard CEA mode timings and the raster-total helper
// shared by video_timing_gen and its users.
package video_timing_pkg;

  // 1280x720 @ 60 Hz
  localparam int HD720_H_ACTIVE = 1280;
  localparam int HD720_H_FP     = 110;
  localparam int HD720_H_SYNC   = 40;
  localparam int HD720_H_BP     = 220;
  localparam int HD720_V_ACTIVE = 720;
  localparam int HD720_V_FP     = 5;
  localparam int HD720_V_SYNC   = 5;
  localparam int HD720_V_BP     = 20;

  // 640x480 @ 60 Hz
  localparam int SD480_H_ACTIVE = 640;
  localparam int SD480_H_FP     = 16;
  localparam int SD480_H_SYNC   = 96;
  localparam int SD480_H_BP     = 48;
  localparam int SD480_V_ACTIVE = 480;
  localparam int SD480_V_FP     = 10;
  localparam int SD480_V_SYNC   = 2;
  localparam int SD480_V_BP     = 33;

  // Total pixels per line (or lines per frame) for one axis of a mode.
  function automatic int raster_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster timing bundle produced by video_timing_gen.
// master drives, slave (character sprite / TMDS stages) observes. There is no
// valid/ready pair: every cycle with en_in high is one pixel and the bundle
// describes that pixel; with en_in low the bundle holds and nf_out is 0.
interface video_timing_gen_if #(
  parameter int HW  = 11,
  parameter int VW  = 10,
  parameter int FCW = 6,
  parameter int CW  = 7,
  parameter int RW  = 6,
  parameter int GXW = 4,
  parameter int GYW = 4
);
  logic [HW-1:0]  hcount_out;
  logic [VW-1:0]  vcount_out;
  logic           hs_out;
  logic           vs_out;
  logic           ad_out;
  logic           nf_out;
  logic [FCW-1:0] fc_out;
  logic [CW-1:0]  cell_col_out;
  logic [RW-1:0]  cell_row_out;
  logic [GXW-1:0] glyph_x_out;
  logic [GYW-1:0] glyph_y_out;

  modport master (
    output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
           cell_col_out, cell_row_out, glyph_x_out, glyph_y_out
  );

  modport slave (
    input hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out,
          cell_col_out, cell_row_out, glyph_x_out, glyph_y_out
  );
endinterface

// File: rtl/video_timing_gen_cell_mapper.sv
// cell_mapper: registered character-cell / glyph decode of the next raster
// position, with a row-scroll offset captured once per frame.
module cell_mapper
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = HD720_H_ACTIVE,
  parameter int V_ACTIVE = HD720_V_ACTIVE,
  parameter int GLYPH_W  = 16,
  parameter int GLYPH_H  = 16,
  parameter int HW       = 11,
  parameter int VW       = 10,
  parameter int ROWS     = V_ACTIVE / GLYPH_H,
  parameter int CW       = $clog2(H_ACTIVE / GLYPH_W),
  parameter int RW       = $clog2(ROWS),
  parameter int GXW      = $clog2(GLYPH_W),
  parameter int GYW      = $clog2(GLYPH_H)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           load,
  input  logic           active,
  input  logic [HW-1:0]  h_next,
  input  logic [VW-1:0]  v_next,
  input  logic [RW-1:0]  row_offset,
  output logic [CW-1:0]  cell_col,
  output logic [RW-1:0]  cell_row,
  output logic [GXW-1:0] glyph_x,
  output logic [GYW-1:0] glyph_y
);
  localparam int           RW1    = RW + 1;
  localparam logic [RW:0]  ROWS_W = RW1'(ROWS);

  logic [RW-1:0] offset;
  logic [RW-1:0] offset_mod;
  logic [RW-1:0] row_wrapped;
  logic [RW:0]   offset_ext;
  logic [RW:0]   row_sum;

  // Fold the requested offset and the scrolled row into 0..ROWS-1. ROWS need
  // not be a power of two, and both operands are already below 2*ROWS, so one
  // conditional subtraction is enough.
  always_comb begin
    offset_ext  = {1'b0, row_offset};
    offset_mod  = (offset_ext >= ROWS_W) ? RW'(offset_ext - ROWS_W) : row_offset;
    row_sum     = RW1'(v_next >> GYW) + {1'b0, offset};
    row_wrapped = (row_sum >= ROWS_W) ? RW'(row_sum - ROWS_W) : row_sum[RW-1:0];
  end

  // Capture the offset on new-frame and register the cell decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset   <= '0;
      cell_col <= '0;
      cell_row <= '0;
      glyph_x  <= '0;
      glyph_y  <= '0;
    end else if (en) begin
      if (load) offset <= offset_mod;
      if (active) begin
        cell_col <= CW'(h_next >> GXW);
        cell_row <= row_wrapped;
        glyph_x  <= h_next[GXW-1:0];
        glyph_y  <= v_next[GYW-1:0];
      end else begin
        cell_col <= '0;
        cell_row <= '0;
        glyph_x  <= '0;
        glyph_y  <= '0;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator (counters, sync,
// active draw, new-frame, frame count) with optional character-cell decode.
// Build option: define VIDEO_TIMING_GEN_CELL_EN to build the cell/glyph
// decode and scroll offset; otherwise the cell outputs are tied to 0.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = HD720_H_ACTIVE,
  parameter int H_FP     = HD720_H_FP,
  parameter int H_SYNC   = HD720_H_SYNC,
  parameter int H_BP     = HD720_H_BP,
  parameter int V_ACTIVE = HD720_V_ACTIVE,
  parameter int V_FP     = HD720_V_FP,
  parameter int V_SYNC   = HD720_V_SYNC,
  parameter int V_BP     = HD720_V_BP,
  parameter bit SYNC_POL = 1'b1,
  parameter int FC_MAX   = 60,
  parameter int GLYPH_W  = 16,
  parameter int GLYPH_H  = 16
) (
  input  logic                                pixel_clk_in,
  input  logic                                rst_in,
  input  logic                                en_in,
  input  logic [$clog2(V_ACTIVE/GLYPH_H)-1:0] row_offset_in,
  video_timing_gen_if.master                  vid
);
  localparam int H_TOTAL  = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int FCW      = $clog2(FC_MAX);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FC_MAX - 1);

  logic [1:0]     rst_sync;
  logic           rst_n;
  logic [HW-1:0]  hcount, h_next;
  logic [VW-1:0]  vcount, v_next;
  logic           hs, vs, ad, nf;
  logic           hs_next, vs_next, ad_next, nf_next;
  logic [FCW-1:0] fc;

  // Assert asynchronously, release two clock edges after rst_in rises.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Next raster position and its decodes; the registers below load these so
  // every output describes the position shown on hcount/vcount.
  always_comb begin
    h_next = hcount + 1'b1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end
    hs_next = (32'(h_next) >= HS_START && 32'(h_next) < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_next = (32'(v_next) >= VS_START && 32'(v_next) < VS_END) ? SYNC_POL : ~SYNC_POL;
    ad_next = (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
    nf_next = (32'(h_next) == H_ACTIVE) && (32'(v_next) == V_ACTIVE);
  end

  // Advance the raster while enabled; nf is a single enabled-cycle pulse.
  always_ff @(posedge pixel_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= H_LAST;
      vcount <= V_LAST;
      hs     <= ~SYNC_POL;
      vs     <= ~SYNC_POL;
      ad     <= 1'b0;
      nf     <= 1'b0;
      fc     <= '0;
    end else if (en_in) begin
      hcount <= h_next;
      vcount <= v_next;
      hs     <= hs_next;
      vs     <= vs_next;
      ad     <= ad_next;
      nf     <= nf_next;
      if (nf_next) fc <= (fc == FC_LAST) ? '0 : fc + 1'b1;
    end else begin
      nf <= 1'b0;
    end
  end

  assign vid.hcount_out = hcount;
  assign vid.vcount_out = vcount;
  assign vid.hs_out     = hs;
  assign vid.vs_out     = vs;
  assign vid.ad_out     = ad;
  assign vid.nf_out     = nf;
  assign vid.fc_out     = fc;

`ifdef VIDEO_TIMING_GEN_CELL_EN
  cell_mapper #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .GLYPH_W  (GLYPH_W),
    .GLYPH_H  (GLYPH_H),
    .HW       (HW),
    .VW       (VW)
  ) u_cell_mapper (
    .clk        (pixel_clk_in),
    .rst_n      (rst_n),
    .en         (en_in),
    .load       (nf_next),
    .active     (ad_next),
    .h_next     (h_next),
    .v_next     (v_next),
    .row_offset (row_offset_in),
    .cell_col   (vid.cell_col_out),
    .cell_row   (vid.cell_row_out),
    .glyph_x    (vid.glyph_x_out),
    .glyph_y    (vid.glyph_y_out)
  );
`else
  logic unused_row_offset;
  assign unused_row_offset = ^row_offset_in;
  assign vid.cell_col_out  = '0;
  assign vid.cell_row_out  = '0;
  assign vid.glyph_x_out   = '0;
  assign vid.glyph_y_out   = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen on a small raster
// (48x32 total, 32x24 active, 8x8 glyphs, 3 text rows, active-low sync).
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int HA = 32, HFP = 4, HSY = 4, HBP = 8;
  localparam int VA = 24, VFP = 2, VSY = 2, VBP = 4;
  localparam bit SP = 1'b0;
  localparam int FCM = 5, GW = 8, GH = 8;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int ROWS = VA / GH, COLS = HA / GW;
  localparam int HW = $clog2(HT), VW = $clog2(VT), FCW = $clog2(FCM);
  localparam int CW = $clog2(COLS), RW = $clog2(ROWS);
  localparam int GXW = $clog2(GW), GYW = $clog2(GH);
  localparam int VEC_W = HW + VW + 4 + FCW + CW + RW + GXW + GYW;
`ifdef VIDEO_TIMING_GEN_CELL_EN
  localparam bit CELL_EN = 1'b1;
`else
  localparam bit CELL_EN = 1'b0;
`endif

  // Clock and reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [RW-1:0] row_off = '0;
  always #5 clk = ~clk;

  video_timing_gen_if #(.HW(HW), .VW(VW), .FCW(FCW), .CW(CW), .RW(RW),
                        .GXW(GXW), .GYW(GYW)) vid ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(SP), .FC_MAX(FCM), .GLYPH_W(GW), .GLYPH_H(GH)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst_n),
    .en_in         (en),
    .row_offset_in (row_off),
    .vid           (vid)
  );

  // Scoreboard and counters
  logic [VEC_W-1:0] exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "init";

  // Reference model of the raster
  int mh, mv, mfc, moff, mcol, mrow, mgx, mgy, sync_cnt;
  bit mhs, mvs, mad, mnf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      $error("check %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mh = HT - 1; mv = VT - 1; mfc = 0; moff = 0;
    mhs = !SP; mvs = !SP; mad = 0; mnf = 0;
    mcol = 0; mrow = 0; mgx = 0; mgy = 0;
    sync_cnt = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin model_reset(); return; end
    if (sync_cnt < 2) begin sync_cnt++; return; end
    if (!en) begin mnf = 0; return; end
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    mnf = (mh == HA) && (mv == VA);
    if (mnf) begin
      mfc  = (mfc + 1) % FCM;
      moff = int'(row_off) % ROWS;
    end
    mhs = (mh >= HA + HFP && mh < HA + HFP + HSY) ? SP : !SP;
    mvs = (mv >= VA + VFP && mv < VA + VFP + VSY) ? SP : !SP;
    mad = (mh < HA) && (mv < VA);
    if (CELL_EN && mad) begin
      mcol = mh / GW; mgx = mh % GW; mgy = mv % GH;
      mrow = (mv / GH + moff) % ROWS;
    end else begin
      mcol = 0; mrow = 0; mgx = 0; mgy = 0;
    end
  endtask

  function automatic logic [VEC_W-1:0] model_vec();
    return {HW'(mh), VW'(mv), mhs, mvs, mad, mnf, FCW'(mfc), CW'(mcol),
            RW'(mrow), GXW'(mgx), GYW'(mgy)};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {vid.hcount_out, vid.vcount_out, vid.hs_out, vid.vs_out, vid.ad_out,
            vid.nf_out, vid.fc_out, vid.cell_col_out, vid.cell_row_out,
            vid.glyph_x_out, vid.glyph_y_out};
  endfunction

  task automatic compare_head();
    logic [VEC_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty queue expected one entry", cur_tag);
    end else begin
      e = exp_q.pop_front();
      check(cur_tag, 32'(dut_vec()), 32'(e));
    end
  endtask

  // Driver: one clock edge with the current inputs, then compare.
  task automatic step();
    model_edge();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Driver: assert rst_in between edges and check the immediate effect.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(model_vec());
    #1;
    compare_head();
  endtask

  int  nf_total, last_nf, ad_cnt, hs_cnt, vs_cnt, nf_cnt, wraps, prev_fc;
  bit  reached;

  initial begin
    // Let the reset synchroniser settle so the reset edge is seen cleanly.
    repeat (3) @(posedge clk);
    #1;
    cur_tag = "reset_async";
    async_reset();
    check("reset_h", 32'(vid.hcount_out), 32'(HT - 1));
    check("reset_v", 32'(vid.vcount_out), 32'(VT - 1));
    check("reset_hs", 32'(vid.hs_out), 32'(!SP));
    en = 1'b1;
    cur_tag = "reset_hold";
    repeat (2) step();
    rst_n = 1'b1;
    cur_tag = "reset_sync";
    repeat (2) step();
    cur_tag = "first_pixel";
    step();
    check("first_h", 32'(vid.hcount_out), 32'd0);
    check("first_v", 32'(vid.vcount_out), 32'd0);
    check("first_ad", 32'(vid.ad_out), 32'd1);

    // Three frames: nf spacing, active/sync counts, scroll timing.
    cur_tag = "frames";
    nf_total = 0; last_nf = -1; ad_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 1; i < 3 * FRAME; i++) begin
      if (i == 10 * HT) row_off = RW'(2);
      step();
      if (vid.ad_out) ad_cnt++;
      if (vid.hs_out == SP) hs_cnt++;
      if (vid.vs_out == SP) vs_cnt++;
      if (vid.nf_out) begin
        check("nf_h", 32'(vid.hcount_out), 32'(HA));
        check("nf_v", 32'(vid.vcount_out), 32'(VA));
        if (last_nf >= 0) begin
          check("nf_interval", 32'(i - last_nf), 32'(FRAME));
          check("ad_per_frame", 32'(ad_cnt), 32'(HA * VA));
          check("hs_low_per_frame", 32'(hs_cnt), 32'(HSY * VT));
          check("vs_low_per_frame", 32'(vs_cnt), 32'(VSY * HT));
        end
        last_nf = i; ad_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        nf_total++;
      end
      if (nf_total == 0 && mh == 0 && mv == 16)
        check("scroll_midframe_ignored", 32'(vid.cell_row_out), CELL_EN ? 32'd2 : 32'd0);
      if (nf_total == 1 && mh == 0 && mv == 0)
        check("scroll_row_v0", 32'(vid.cell_row_out), CELL_EN ? 32'd2 : 32'd0);
      if (nf_total == 1 && mh == 0 && mv == 8)
        check("scroll_row_v8", 32'(vid.cell_row_out), 32'd0);
      if (nf_total == 1 && mh == HA - 1 && mv == VA - 1) begin
        check("last_cell_col", 32'(vid.cell_col_out), CELL_EN ? 32'(COLS - 1) : 32'd0);
        check("last_glyph_x", 32'(vid.glyph_x_out), CELL_EN ? 32'(GW - 1) : 32'd0);
        check("last_glyph_y", 32'(vid.glyph_y_out), CELL_EN ? 32'(GH - 1) : 32'd0);
      end
    end
    check("nf_count_3_frames", 32'(nf_total), 32'd3);

    // Freeze for 100 cycles just before the new-frame position.
    cur_tag = "seek_en";
    reached = 1'b0;
    for (int i = 0; i < FRAME && !reached; i++) begin
      if (mh == HA - 1 && mv == VA) reached = 1'b1;
      else step();
    end
    check("en_pos_reached", 32'(reached), 32'd1);
    en = 1'b0;
    cur_tag = "en_low";
    nf_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (vid.nf_out) nf_cnt++;
    end
    check("en_hold_h", 32'(vid.hcount_out), 32'(HA - 1));
    check("en_hold_v", 32'(vid.vcount_out), 32'(VA));
    check("en_low_no_nf", 32'(nf_cnt), 32'd0);
    en = 1'b1;
    cur_tag = "en_release";
    step();
    check("en_release_nf", 32'(vid.nf_out), 32'd1);
    nf_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (vid.nf_out) nf_cnt++;
    end
    check("en_release_nf_once", 32'(nf_cnt), 32'd1);

    // Frame counter wrap over FC_MAX frames.
    cur_tag = "fc_wrap";
    wraps = 0;
    prev_fc = mfc;
    for (int i = 0; i < FCM * FRAME; i++) begin
      step();
      if (vid.nf_out) begin
        if (prev_fc == FCM - 1 && int'(vid.fc_out) == 0) wraps++;
        prev_fc = int'(vid.fc_out);
      end
    end
    check("fc_wrap_once", 32'(wraps), 32'd1);

    // Reset pulsed mid-line.
    cur_tag = "seek_mid";
    reached = 1'b0;
    for (int i = 0; i < HT && !reached; i++) begin
      if (mh == 10) reached = 1'b1;
      else step();
    end
    check("mid_line_reached", 32'(reached), 32'd1);
    cur_tag = "reset_mid";
    async_reset();
    check("reset_mid_h", 32'(vid.hcount_out), 32'(HT - 1));
    check("reset_mid_ad", 32'(vid.ad_out), 32'd0);
    check("reset_mid_nf", 32'(vid.nf_out), 32'd0);
    check("reset_mid_fc", 32'(vid.fc_out), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    cur_tag = "restart_sync";
    repeat (2) step();
    cur_tag = "restart";
    step();
    check("restart_h", 32'(vid.hcount_out), 32'd0);
    check("restart_v", 32'(vid.vcount_out), 32'd0);
    check("restart_ad", 32'(vid.ad_out), 32'd1);
    repeat (20) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI display path, generalising the fixed 720p signal generator. It produces counters, sync, active-draw, new-frame and frame-count signals for any CEA-style mode. It also produces terminal character-cell coordinates with a frame-latched hardware row-scroll offset. It sits between the pixel clock domain and the character sprite and TMDS encoder stages.

## Interface
Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, visible lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vertical sync width
- V_BP, 20, vertical back porch
- SYNC_POL, 1, asserted level of hs_out/vs_out
- FC_MAX, 60, frame counter modulus
- GLYPH_W, 16, cell width in pixels, power of two
- GLYPH_H, 16, cell height in lines, power of two

Derived values:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
- HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL)
- ROWS = V_ACTIVE / GLYPH_H, COLS = H_ACTIVE / GLYPH_W

Ports:
- pixel_clk_in  in  1  pixel clock; single clock domain
- rst_in  in  1  asynchronous, active-low reset
- en_in  in  1  advance timing; low freezes all state
- row_offset_in  in  $clog2(ROWS)  scroll offset, sampled on new frame
- hcount_out  out  HW  current pixel column
- vcount_out  out  VW  current line
- hs_out  out  1  horizontal sync
- vs_out  out  1  vertical sync
- ad_out  out  1  active draw
- nf_out  out  1  new-frame pulse
- fc_out  out  $clog2(FC_MAX)  frame count
- cell_col_out  out  $clog2(COLS)  character column
- cell_row_out  out  $clog2(ROWS)  scrolled character row
- glyph_x_out  out  $clog2(GLYPH_W)  pixel within cell
- glyph_y_out  out  $clog2(GLYPH_H)  line within cell

## Operation
- All outputs are registered and describe the position shown on hcount_out/vcount_out in the same cycle.
- hcount runs 0..H_TOTAL-1, then wraps to 0 and increments vcount. vcount wraps at V_TOTAL-1 to 0.
- hs_out = SYNC_POL when hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise ~SYNC_POL.
- vs_out is defined the same way, using vcount and the vertical parameters.
- ad_out = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- nf_out is high for one enabled cycle at (H_ACTIVE, V_ACTIVE).
- fc_out increments in the same cycle that nf_out is high, wrapping FC_MAX-1 → 0.
- row_offset_in is latched into an internal offset register on the nf_out cycle. Mid-frame changes have no effect until the next frame.
- During active draw:
  - cell_col_out = hcount >> log2(GLYPH_W)
  - glyph_x_out = hcount[low bits]
  - glyph_y_out = vcount[low bits]
  - cell_row_out = ((vcount >> log2(GLYPH_H)) + offset) mod ROWS, wrapping explicitly because ROWS need not be a power of two
- Outside active draw, all four cell outputs are 0.
- en_in low: counters, fc and offset hold; nf_out is forced 0; all other outputs hold their values.

## Timing
- Reset values (async assert, held while rst_in low):
  - hcount_out = H_TOTAL-1, vcount_out = V_TOTAL-1
  - ad_out = 0, nf_out = 0, fc_out = 0, offset = 0
  - hs_out = vs_out = ~SYNC_POL
  - all cell outputs = 0
- First enabled edge after reset release: (0,0) with ad_out = 1.
- Reset release is synchronised internally; deassertion takes effect on the clock edge after the synchroniser, asynchronous assertion is immediate.
- Latency from counter to decode is 0 cycles as seen at the ports; decodes are computed from next-state values.
- Frame period: H_TOTAL × V_TOTAL enabled cycles. The interval between nf_out pulses is exactly one frame period.
- Reset asserted mid-frame aborts immediately; no partial nf_out is produced.

## Configuration
- Macro VIDEO_TIMING_GEN_CELL_EN.
- When defined: the cell/glyph logic and the offset register are built as specified above.
- When undefined: cell_col_out, cell_row_out, glyph_x_out and glyph_y_out are tied to 0 and row_offset_in is ignored. All other behaviour is unchanged.

## Structure
- Shared package video_timing_pkg holds:
  - 720p and 480p localparam sets (H_*/V_* values for each mode)
  - a function that computes H_TOTAL/V_TOTAL
- One sub-module, cell_mapper, holds the registered cell/glyph decode and scroll offset. It is instantiated only under VIDEO_TIMING_GEN_CELL_EN.

## Test plan
- Default params, en_in = 1, two frames:
  - nf_out pulses at (1280,720) exactly 1650×750 cycles apart
  - ad_out high for 921600 cycles per frame
- Sync windows with SYNC_POL = 0:
  - hs_out low for hcount 1390..1429 and high elsewhere
  - vs_out low for vcount 725..729
- Scroll:
  - row_offset_in = 44 set mid-frame has no effect on that frame
  - next frame at vcount 0 gives cell_row_out = 44; at vcount 16 it gives 0
  - at (1279,719): cell_col_out = 79, glyph_x_out = 15, glyph_y_out = 15
- en_in low for 100 cycles at (1279,720):
  - counters hold for all 100 cycles
  - on release, nf_out fires exactly once
- fc_out wrap: 60 frames returns fc_out from 59 to 0.
- rst_in pulsed low mid-line:
  - outputs take reset values immediately
  - first enabled cycle after release shows (0,0) with ad_out = 1
